relu_pack: RTL and testbench
============================

# relu_pack

Downstream of the row-accumulating summation stage. Takes its serial stream of accumulated totals (one `BitSize` signed value per cycle, `in_start` on the first of each group), applies ReLU, rounding right-shift and unsigned saturation to `OutBitSize`, and re-packs each group of `NumOfNerves` results into one parallel vector. The vector is presented to the next layer with a valid/ready handshake.

## Interface
Parameters:
- `BitSize`, 8: width of incoming signed totals.
- `OutBitSize`, 4: width of each packed unsigned output element; must be at most `BitSize`.
- `NumOfNerves`, 4: elements per packed vector; must be ≥ 2.
- `Shift`, 2: rounding right-shift amount; range 0 to `BitSize`-1.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `res_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_data` carries an element this cycle.
- `in_start` in 1: qualified by `in_valid`; marks the first element of a group.
- `in_data` in `BitSize`: signed two's-complement total.
- `out_valid` out 1: `out_data` holds a complete vector.
- `out_ready` in 1: consumer accepts the vector when `out_valid` and `out_ready` are both high.
- `out_data` out `[NumOfNerves-1:0][OutBitSize-1:0]`: packed vector.
- `err` out 1: one-cycle pulse on any protocol fault.
- `err_sticky` out 1: set by `err`; cleared only by reset.

## Operation
Per-element quantisation (combinational):
- If `x < 0`, the result is 0.
- Otherwise, for `Shift > 0`: `y = (x + 2^(Shift-1)) >> Shift`, computed at `BitSize+1` bits so the addition cannot overflow. For `Shift = 0`: `y = x`.
- Output is `min(y, 2^OutBitSize - 1)`.

Packing:
- An element index `idx` counts 0 to `NumOfNerves`. Value `NumOfNerves` means idle/no group open. The reset value is idle.
- `in_valid & in_start`: the element goes to lane `NumOfNerves-1`, and `idx` becomes 1. If a partial group was open (`idx` not 0 and not idle), it is discarded and `err` pulses.
- `in_valid & !in_start` with a group open: the element goes to lane `NumOfNerves-1-idx`, and `idx` increments. Lane order therefore matches the original nerve index, because upstream emits the highest nerve first.
- `in_valid & !in_start` while idle: the element is ignored and `err` pulses.
- When the element that completes a group arrives:
  - The full vector (with the final lane taken combinationally) loads the output register.
  - `out_valid` is set and `idx` goes to idle.
- Output register behaviour:
  - It holds `out_data` and `out_valid` stable until a handshake completes.
  - On a handshake with no new load, `out_valid` clears. `out_data` keeps its last value.
- Load while occupied:
  - If the output register is occupied and not handshaking in that cycle, the new vector is dropped, the old vector is kept, and `err` pulses.
  - A handshake and a load in the same cycle are legal: the new vector replaces the old one and `out_valid` stays high.
- There is no backpressure to upstream, which has none.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `err`=0, `err_sticky`=0, assembly lanes=0, `idx`=idle.
- Latency: the last element is accepted at the cycle-t edge, and `out_valid`/`out_data` are visible from cycle t+1.
- Throughput: one element per cycle. Back-to-back groups with `out_ready` held high sustain without error.
- `err` is registered and asserts in the cycle after the faulting input. `err_sticky` rises in the same cycle as `err`.
- Reset asserted mid-group or mid-handshake: all state returns to reset values immediately. The partial group is lost and no `err` is raised.

## Structure
- Package `relu_pack_pkg` holds:
  - element typedefs parameterised by width via a `localparam` pattern;
  - a `quantize` function (ReLU, round, saturate) shared with other layer stages;
  - the `idx` width constant `$clog2(NumOfNerves+1)`.
- Sub-module `relu_quant`: purely combinational `BitSize` to `OutBitSize` element converter. It is instantiated once and driven by `in_data`.
- The top level contains the index counter, assembly register, output register/handshake and error logic.

## Test plan
- Defaults, `out_ready`=1, inputs 40 (start), -5, 100, 6 on consecutive cycles → one cycle later `out_valid`=1 and `out_data`=16'hA0F2. Lanes: [3]=10, [2]=0, [1]=15 (saturated), [0]=2.
- `out_ready`=0 during the group above, raised 3 cycles after `out_valid` → `out_data` stays 16'hA0F2 throughout. `out_valid` drops the cycle after the handshake.
- Second group completes while the first is unaccepted and `out_ready`=0 → first vector kept, `err` pulse, `err_sticky`=1. With `out_ready`=1 in the completion cycle → new vector replaces the old one and there is no `err`.
- `in_start` after 2 elements, then 4 elements 4, 8, 12, 16 → `err` pulse, and the output is the new group only: lanes [3..0] = 1, 2, 3, 4, i.e. 16'h1234.
- `in_valid` without `in_start` after reset → no `out_valid`, `err` pulse. `res_n` low mid-group → all outputs 0, and the next group packs correctly.
- `Shift`=0, `OutBitSize`=8, `BitSize`=8: inputs 127, -128, 0, 1 → 32'h7F000001.

Source files
------------

// File: rtl/relu_pack_pkg.sv
// Shared types and helpers for the ReLU/quantise/pack layer stages.
// Element typedefs use the default layer widths; wider users size their own.
package relu_pack_pkg;

  localparam int BIT_SIZE      = 8;
  localparam int OUT_BIT_SIZE  = 4;
  localparam int NUM_OF_NERVES = 4;
  localparam int IDX_W         = $clog2(NUM_OF_NERVES + 1);

  typedef logic signed [BIT_SIZE-1:0] total_t;
  typedef logic [OUT_BIT_SIZE-1:0]    elem_t;

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

  // ReLU, round-half-up right shift, unsigned saturation to out_bits.
  // Works on a 32-bit container so callers of any width up to 31 bits can share it.
  function automatic logic [31:0] quantize(input logic signed [31:0] x,
                                           input int shift,
                                           input int out_bits);
    logic [32:0] sum;
    logic [31:0] y;
    logic [31:0] max_v;
    if (x < 0) return '0;
    sum = {1'b0, x};
    if (shift > 0) sum = sum + (33'd1 << (shift - 1));
    y     = 32'(sum >> shift);
    max_v = (32'd1 << out_bits) - 32'd1;
    return (y > max_v) ? max_v : y;
  endfunction

endpackage

// File: rtl/relu_quant.sv
// Combinational element converter: signed BitSize total to saturated unsigned OutBitSize.
module relu_quant
  import relu_pack_pkg::*;
#(
  parameter int BitSize    = 8,
  parameter int OutBitSize = 4,
  parameter int Shift      = 2
) (
  input  logic [BitSize-1:0]    in_data,
  output logic [OutBitSize-1:0] q
);

  assign q = OutBitSize'(quantize(32'(signed'(in_data)), Shift, OutBitSize));

endmodule

// File: rtl/relu_pack.sv
// Quantises a serial stream of accumulated totals and packs each group into
// one parallel vector offered downstream through a valid/ready register.
module relu_pack
  import relu_pack_pkg::*;
#(
  parameter int BitSize     = 8,
  parameter int OutBitSize  = 4,
  parameter int NumOfNerves = 4,
  parameter int Shift       = 2
) (
  input  logic                                   clk,
  input  logic                                   res_n,
  input  logic                                   in_valid,
  input  logic                                   in_start,
  input  logic [BitSize-1:0]                     in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NumOfNerves-1:0][OutBitSize-1:0] out_data,
  output logic                                   err,
  output logic                                   err_sticky
);

  localparam int IdxW = idx_width(NumOfNerves);
  localparam logic [IdxW-1:0] IDX_IDLE = IdxW'(NumOfNerves);
  localparam logic [IdxW-1:0] IDX_LAST = IdxW'(NumOfNerves - 1);

  logic [IdxW-1:0]                         idx;
  logic [NumOfNerves-1:0][OutBitSize-1:0] asm_q;
  logic [NumOfNerves-1:0][OutBitSize-1:0] full_vec;
  logic [OutBitSize-1:0]                   q;
  logic grp_start, grp_cont, orphan, partial, load, accept, err_d;

  relu_quant #(
    .BitSize    (BitSize),
    .OutBitSize (OutBitSize),
    .Shift      (Shift)
  ) u_quant (
    .in_data (in_data),
    .q       (q)
  );

  always_comb begin
    grp_start = in_valid & in_start;
    grp_cont  = in_valid & ~in_start & (idx != IDX_IDLE);
    orphan    = in_valid & ~in_start & (idx == IDX_IDLE);
    partial   = grp_start & (idx != '0) & (idx != IDX_IDLE);
    load      = grp_cont & (idx == IDX_LAST);
    // A completing vector may only land if the register is free or emptying now.
    accept    = load & (~out_valid | out_ready);
    err_d     = partial | orphan | (load & ~accept);
    full_vec    = asm_q;
    full_vec[0] = q;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      idx        <= IDX_IDLE;
      asm_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (grp_start) begin
        asm_q[NumOfNerves-1] <= q;
        idx                  <= IdxW'(1);
      end else if (grp_cont) begin
        for (int i = 0; i < NumOfNerves; i++) begin
          if (IdxW'(NumOfNerves - 1 - i) == idx) asm_q[i] <= q;
        end
        idx <= load ? IDX_IDLE : idx + IdxW'(1);
      end

      if (accept) begin
        out_data  <= full_vec;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end

      err        <= err_d;
      err_sticky <= err_sticky | err_d;
    end
  end

endmodule

// File: tb/tb_relu_pack.sv
// Scoreboard bench for relu_pack: directed cases plus randomized traffic.
module tb_relu_pack;
  import relu_pack_pkg::*;

  localparam int N  = 4;
  localparam int OB = 4;
  localparam int SH = 2;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic in_valid = 1'b0, in_start = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic out_valid, err, err_sticky;
  logic [N-1:0][OB-1:0] out_data;

  logic in_valid2 = 1'b0, in_start2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic out_valid2, err2, err_sticky2;
  logic [3:0][7:0] out_data2;

  always #5 clk = ~clk;

  relu_pack #(.BitSize(8), .OutBitSize(OB), .NumOfNerves(N), .Shift(SH)) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_start(in_start),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err), .err_sticky(err_sticky));

  relu_pack #(.BitSize(8), .OutBitSize(8), .NumOfNerves(4), .Shift(0)) dut8 (
    .clk(clk), .res_n(res_n), .in_valid(in_valid2), .in_start(in_start2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_data(out_data2), .err(err2), .err_sticky(err_sticky2));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: integer arithmetic and an element queue per group.
  function automatic int qmodel(input int x, input int sh, input int ob);
    int y;
    if (x < 0) return 0;
    y = (sh > 0) ? (x + (1 << (sh - 1))) / (1 << sh) : x;
    return (y > (1 << ob) - 1) ? (1 << ob) - 1 : y;
  endfunction

  int          cur[$];
  bit          grp_open = 0;
  bit          occ = 0;
  logic [15:0] exp_q[$];
  int          exp_err = 0, exp_err_since_rst = 0, obs_err = 0;

  task automatic model_step(input bit v, input bit s, input logic [7:0] d, input bit rdy);
    bit complete = 0;
    logic [15:0] vec = '0;
    if (v) begin
      if (s) begin
        if (grp_open && cur.size() > 0) begin exp_err++; exp_err_since_rst++; end
        cur.delete();
        cur.push_back(qmodel(int'($signed(d)), SH, OB));
        grp_open = 1;
      end else if (!grp_open) begin
        exp_err++; exp_err_since_rst++;
      end else begin
        cur.push_back(qmodel(int'($signed(d)), SH, OB));
        if (cur.size() == N) begin complete = 1; grp_open = 0; end
      end
    end
    if (complete) begin
      for (int i = 0; i < N; i++) vec = vec | (16'(cur[i]) << (OB * (N - 1 - i)));
      cur.delete();
      if (!occ || rdy) begin exp_q.push_back(vec); occ = 1; end
      else begin exp_err++; exp_err_since_rst++; end
    end else if (occ && rdy) begin
      occ = 0;
    end
  endtask

  task automatic cycle(input bit v, input bit s, input int d, input bit rdy);
    @(posedge clk); #1;
    in_valid = v; in_start = s; in_data = 8'(d); out_ready = rdy;
    model_step(v, s, 8'(d), rdy);
  endtask

  task automatic group4(input int a, input int b, input int c, input int e, input bit rdy);
    cycle(1, 1, a, rdy); cycle(1, 0, b, rdy); cycle(1, 0, c, rdy); cycle(1, 0, e, rdy);
  endtask

  task automatic settle(input bit rdy);
    cycle(0, 0, 0, rdy);
    @(negedge clk); #1;
  endtask

  task automatic check_err(input string name);
    chk(obs_err == exp_err, {name, "_err_count"}, 64'(obs_err), 64'(exp_err));
    chk(err_sticky == (exp_err_since_rst != 0), {name, "_sticky"}, 64'(err_sticky), 64'(exp_err_since_rst != 0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    res_n = 1'b0; in_valid = 0; in_start = 0; out_ready = 0;
    in_valid2 = 0; in_start2 = 0;
    cur.delete(); grp_open = 0; occ = 0; exp_q.delete(); exp_err_since_rst = 0;
    #2;
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 0);
    chk(out_data == '0, "rst_out_data", 64'(out_data), 0);
    chk(err == 1'b0, "rst_err", 64'(err), 0);
    chk(err_sticky == 1'b0, "rst_sticky", 64'(err_sticky), 0);
    @(posedge clk); #1;
    res_n = 1'b1;
  endtask

  // Monitor: counts err pulses and checks every accepted vector against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (res_n) begin
        if (err) obs_err++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk(0, "unexpected_vector", 64'(out_data), 0);
          else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            chk(out_data == e, "vector", 64'(out_data), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    do_reset();

    // Basic group, consumer ready: visible one cycle after last element.
    group4(40, -5, 100, 6, 1);
    settle(1);
    chk(out_valid == 1'b1, "latency_valid", 64'(out_valid), 1);
    chk(out_data == 16'hA0F2, "latency_data", 64'(out_data), 64'hA0F2);
    settle(1);
    chk(out_valid == 1'b0, "drain_valid", 64'(out_valid), 0);

    // Held under backpressure, released after three cycles.
    group4(40, -5, 100, 6, 0);
    for (int i = 0; i < 3; i++) begin
      settle(0);
      chk(out_valid == 1'b1 && out_data == 16'hA0F2, "hold", 64'({out_valid, out_data}), 64'h1A0F2);
    end
    settle(1);
    settle(0);
    chk(out_valid == 1'b0, "drop_after_hs", 64'(out_valid), 0);
    check_err("hold");

    // Completion while occupied and not ready: dropped with err.
    group4(16, 16, 16, 16, 0);
    group4(60, 60, 60, 60, 0);
    settle(0);
    check_err("overflow");
    settle(1);
    settle(1);
    // Completion with ready in the same cycle: replacement without err.
    group4(4, 8, 12, 16, 0);
    cycle(1, 1, 60, 0); cycle(1, 0, 50, 0); cycle(1, 0, 40, 0); cycle(1, 0, 30, 1);
    settle(1);
    settle(1);
    check_err("replace");

    // Restart mid-group.
    cycle(1, 1, 20, 1); cycle(1, 0, 24, 1);
    group4(4, 8, 12, 16, 1);
    settle(1);
    chk(out_data == 16'h1234, "restart_data", 64'(out_data), 64'h1234);
    settle(1);
    check_err("restart");

    // Orphan element after reset, then reset mid-group.
    do_reset();
    cycle(1, 0, 33, 1);
    settle(1);
    chk(out_valid == 1'b0, "orphan_no_valid", 64'(out_valid), 0);
    check_err("orphan");
    cycle(1, 1, 40, 1); cycle(1, 0, 40, 1);
    do_reset();
    group4(4, 8, 12, 16, 1);
    settle(1);
    chk(out_data == 16'h1234, "post_reset_data", 64'(out_data), 64'h1234);
    settle(1);
    check_err("post_reset");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit v, s, r;
      v = ($urandom_range(0, 4) != 0);
      s = grp_open ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 2) != 0);
      cycle(v, s, int'($urandom_range(0, 255)), r);
    end
    for (int i = 0; i < 4; i++) settle(1);
    check_err("random");
    chk(exp_q.size() == 0, "queue_empty", 64'(exp_q.size()), 0);

    // Wide-output, no-shift instance.
    begin
      int vals[4] = '{127, -128, 0, 1};
      logic [31:0] e8 = '0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        in_valid2 = 1; in_start2 = (i == 0); in_data2 = 8'(vals[i]);
        e8 = e8 | (32'(qmodel(vals[i], 0, 8)) << (8 * (3 - i)));
      end
      @(posedge clk); #1;
      in_valid2 = 0; in_start2 = 0;
      @(negedge clk);
      chk(out_valid2 == 1'b1, "wide_valid", 64'(out_valid2), 1);
      chk(out_data2 == e8, "wide_data_model", 64'(out_data2), 64'(e8));
      chk(out_data2 == 32'h7F000001, "wide_data", 64'(out_data2), 64'h7F000001);
      chk(err_sticky2 == 1'b0, "wide_no_err", 64'(err_sticky2), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
